mem_arb_rr: RTL and testbench



---
 rtl/mem_bus_pkg.sv | 16 +
 rtl/rr_pick.sv | 29 ++
 rtl/mem_arb_rr.sv | 130 +++++++++++++
 tb/tb_mem_arb_rr.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared native-bus definitions for the memory arbiter slice: field widths,
// arbiter state encoding and the default abort data word.
package mem_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: returns the first set bit of mask_i scanning
// last_i+1, last_i+2, ... modulo N, plus a flag telling whether any bit is set.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [2*N-1:0] rot;

  // Doubling the mask turns the modular scan into a plain shift; the
  // descending loop lets the lowest offset from last_i win.
  always_comb begin
    rot   = {mask_i, mask_i} >> (int'(last_i) + 1);
    idx_o = '0;
    any_o = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        idx_o = IW'((int'(last_i) + 1 + j) % N);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arb_rr.sv
// Round-robin arbiter sharing one native memory master port between NPORTS
// requesters, with a per-transaction watchdog that aborts a stuck slave.
module mem_arb_rr
  import mem_bus_pkg::*;
#(
  parameter int                NPORTS   = 3,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT,
  localparam int               IDW      = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        req_valid,
  output logic [NPORTS-1:0]        req_ready,
  input  logic [ADDR_W*NPORTS-1:0] req_addr,
  input  logic [DATA_W*NPORTS-1:0] req_wdata,
  input  logic [STRB_W*NPORTS-1:0] req_wstrb,
  output logic [DATA_W-1:0]        req_rdata,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [STRB_W-1:0]        mem_wstrb,
  output logic                     timeout_err,
  output logic [IDW-1:0]           grant_id
);

  localparam int             WDW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [WDW-1:0]   wdog_q, wdog_d;

  logic              busy, abort, done;
  logic [NPORTS-1:0] excl_mask;
  logic [IDW-1:0]    idle_idx, next_idx;
  logic              idle_any, next_any;

  assign busy  = (state_q == ARB_BUSY);
  // A real completion always beats a watchdog expiry in the same cycle.
  assign abort = busy && !mem_ready && (TIMEOUT != 0) && (wdog_q == WD_LAST);
  assign done  = busy && (mem_ready || abort);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    req_ready = '0;
    excl_mask = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (grant_q == IDW'(i)) begin
        mem_addr  = req_addr[i*ADDR_W +: ADDR_W];
        mem_wdata = req_wdata[i*DATA_W +: DATA_W];
        mem_wstrb = req_wstrb[i*STRB_W +: STRB_W];
        req_ready[i] = done;
      end else begin
        excl_mask[i] = req_valid[i];
      end
    end
  end

  assign mem_valid   = busy;
  assign timeout_err = abort;
  assign grant_id    = grant_q;
  assign req_rdata   = !done ? '0 : (mem_ready ? mem_rdata : ERR_DATA);

  rr_pick #(.N(NPORTS), .IW(IDW)) u_pick_idle (
    .mask_i (req_valid),
    .last_i (last_q),
    .idx_o  (idle_idx),
    .any_o  (idle_any)
  );

  // The finishing port still holds valid, so it is masked out and the scan
  // starts just past it.
  rr_pick #(.N(NPORTS), .IW(IDW)) u_pick_next (
    .mask_i (excl_mask),
    .last_i (grant_q),
    .idx_o  (next_idx),
    .any_o  (next_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    case (state_q)
      ARB_IDLE: begin
        if (idle_any) begin
          grant_d = idle_idx;
          state_d = ARB_BUSY;
          wdog_d  = '0;
        end
      end
      ARB_BUSY: begin
        if (done) begin
          last_d = grant_q;
          if (next_any) begin
            grant_d = next_idx;
            wdog_d  = '0;
          end else begin
            state_d = ARB_IDLE;
          end
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IDW'(NPORTS - 1);
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_mem_arb_rr.sv
// Self-checking bench for mem_arb_rr: directed scenarios with literal
// expectations, then randomized traffic checked against a transaction model.
module tb_mem_arb_rr;

  localparam int NP      = 3;
  localparam int TMO     = 4;
  localparam logic [31:0] ERRW = 32'hDEADBEEF;

  logic         clk = 1'b0;
  logic         rst;
  logic [NP-1:0] req_valid;
  logic [NP-1:0] req_ready;
  logic [32*NP-1:0] req_addr;
  logic [32*NP-1:0] req_wdata;
  logic [4*NP-1:0]  req_wstrb;
  logic [31:0]  req_rdata;
  logic         mem_valid;
  logic         mem_ready;
  logic [31:0]  mem_rdata;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_wstrb;
  logic         timeout_err;
  logic [1:0]   grant_id;

  logic [31:0] addrA [NP];
  logic [31:0] wdataA[NP];
  logic [3:0]  wstrbA[NP];

  assign req_addr  = {addrA[2], addrA[1], addrA[0]};
  assign req_wdata = {wdataA[2], wdataA[1], wdataA[0]};
  assign req_wstrb = {wstrbA[2], wstrbA[1], wstrbA[0]};

  always #5 clk = ~clk;

  mem_arb_rr #(.NPORTS(NP), .TIMEOUT(TMO), .ERR_DATA(ERRW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wstrb   (req_wstrb),
    .req_rdata   (req_rdata),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .timeout_err (timeout_err),
    .grant_id    (grant_id)
  );

  int nChecks = 0;
  int nPass   = 0;

  // Transaction-level model: is a transfer outstanding, which port owns it,
  // who was served last, and how many cycles it has waited.
  bit          modelOn = 1'b0;
  bit          mBusy   = 1'b0;
  int          mPort   = 0;
  int          mLast   = NP - 1;
  int          mWait   = 0;
  logic [NP-1:0] lastExpReady;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int pickModel(input logic [NP-1:0] mask, input int last);
    for (int k = 1; k <= NP; k++) begin
      if (mask[(last + k) % NP]) return (last + k) % NP;
    end
    return -1;
  endfunction

  function automatic bit modelDone();
    return mBusy && (mem_ready || (mWait == TMO - 1));
  endfunction

  task automatic applyStimulus(input logic r, input logic [NP-1:0] v,
                               input logic mr, input logic [31:0] rd);
    rst       = r;
    req_valid = v;
    mem_ready = mr;
    mem_rdata = rd;
    #1;
  endtask

  task automatic checkOutput();
    logic [NP-1:0] expReady;
    logic [31:0]   expRdata;
    bit            d, ab;
    d  = modelDone();
    ab = d && !mem_ready;
    expReady = d ? NP'(1 << mPort) : '0;
    expRdata = !d ? 32'h0 : (mem_ready ? mem_rdata : ERRW);
    lastExpReady = expReady;
    check32("mem_valid", 32'(mem_valid), 32'(mBusy));
    check32("req_ready", 32'(req_ready), 32'(expReady));
    check32("req_rdata", req_rdata, expRdata);
    check32("timeout_err", 32'(timeout_err), 32'(ab));
    if (mBusy) begin
      check32("grant_id", 32'(grant_id), 32'(mPort));
      check32("mem_addr", mem_addr, addrA[mPort]);
      check32("mem_wdata", mem_wdata, wdataA[mPort]);
      check32("mem_wstrb", 32'(mem_wstrb), 32'(wstrbA[mPort]));
    end
  endtask

  task automatic updateModel(input bit d);
    logic [NP-1:0] mask;
    if (rst) begin
      mBusy = 1'b0; mPort = 0; mLast = NP - 1; mWait = 0;
    end else if (!mBusy) begin
      if (req_valid != '0) begin
        mBusy = 1'b1; mPort = pickModel(req_valid, mLast); mWait = 0;
      end
    end else if (d) begin
      mLast = mPort;
      mask  = req_valid & ~NP'(1 << mPort);
      if (mask != '0) begin
        mPort = pickModel(mask, mLast); mWait = 0;
      end else begin
        mBusy = 1'b0;
      end
    end else begin
      mWait++;
    end
  endtask

  task automatic endCycle();
    bit d;
    lastExpReady = '0;
    d = modelDone();
    if (modelOn) checkOutput();
    @(posedge clk);
    updateModel(d);
    @(negedge clk);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, '0, 1'b0, 32'h0);
    endCycle();
    modelOn = 1'b1;
    applyStimulus(1'b1, '0, 1'b0, 32'h0);
    check32("rst_mem_valid", 32'(mem_valid), 32'h0);
    check32("rst_req_ready", 32'(req_ready), 32'h0);
    check32("rst_req_rdata", req_rdata, 32'h0);
    check32("rst_timeout_err", 32'(timeout_err), 32'h0);
    endCycle();
  endtask

  logic [NP-1:0] pend;

  initial begin
    rst = 1'b1; req_valid = '0; mem_ready = 1'b0; mem_rdata = '0;
    for (int i = 0; i < NP; i++) begin
      addrA[i]  = 32'h100 * i;
      wdataA[i] = 32'hA000_0000 + i;
      wstrbA[i] = (i == 0) ? 4'hF : ((i == 1) ? 4'h0 : 4'h3);
    end
    @(negedge clk);
    doReset();

    // Single read on port 1: one-cycle latency, same-cycle completion.
    applyStimulus(1'b0, 3'b010, 1'b0, 32'h0);
    check32("t1_latency", 32'(mem_valid), 32'h0);
    endCycle();
    applyStimulus(1'b0, 3'b010, 1'b1, 32'h12345678);
    check32("t1_grant", 32'(grant_id), 32'h1);
    check32("t1_valid", 32'(mem_valid), 32'h1);
    check32("t1_addr", mem_addr, 32'h100);
    check32("t1_wstrb", 32'(mem_wstrb), 32'h0);
    check32("t1_ready", 32'(req_ready), 32'b010);
    check32("t1_rdata", req_rdata, 32'h12345678);
    endCycle();
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0);
    check32("t1_idle", 32'(mem_valid), 32'h0);
    endCycle();

    // Fairness with all ports requesting from reset.
    doReset();
    applyStimulus(1'b0, 3'b111, 1'b1, 32'h0);
    endCycle();
    for (int n = 0; n < 6; n++) begin
      applyStimulus(1'b0, (n == 5) ? 3'b100 : 3'b111, 1'b1, $urandom);
      check32("t2_grant", 32'(grant_id), 32'(n % 3));
      check32("t2_ready", 32'(req_ready), 32'(1 << (n % 3)));
      endCycle();
    end
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0);
    check32("t2_idle", 32'(mem_valid), 32'h0);
    endCycle();

    // Make port 0 the last served, then ports 0 and 2 compete.
    applyStimulus(1'b0, 3'b001, 1'b0, 32'h0); endCycle();
    applyStimulus(1'b0, 3'b001, 1'b1, 32'h1); endCycle();
    applyStimulus(1'b0, 3'b101, 1'b0, 32'h0); endCycle();
    applyStimulus(1'b0, 3'b101, 1'b1, 32'h2);
    check32("t3_first", 32'(grant_id), 32'h2);
    endCycle();
    applyStimulus(1'b0, 3'b001, 1'b1, 32'h3);
    check32("t3_second", 32'(grant_id), 32'h0);
    check32("t3_ready", 32'(req_ready), 32'b001);
    endCycle();

    // Watchdog abort on the 4th busy cycle, then handoff to port 2.
    applyStimulus(1'b0, 3'b010, 1'b0, 32'h0); endCycle();
    for (int w = 0; w < 3; w++) begin
      applyStimulus(1'b0, 3'b010, 1'b0, 32'h0);
      check32("t4_wait_ready", 32'(req_ready), 32'h0);
      endCycle();
    end
    applyStimulus(1'b0, 3'b110, 1'b0, 32'h0);
    check32("t4_ready", 32'(req_ready), 32'b010);
    check32("t4_rdata", req_rdata, 32'hDEADBEEF);
    check32("t4_terr", 32'(timeout_err), 32'h1);
    check32("t4_valid", 32'(mem_valid), 32'h1);
    endCycle();
    for (int w = 0; w < 3; w++) begin
      applyStimulus(1'b0, 3'b100, 1'b0, 32'h0);
      check32("t5_grant", 32'(grant_id), 32'h2);
      endCycle();
    end
    applyStimulus(1'b0, 3'b100, 1'b1, 32'hCAFEF00D);
    check32("t5_ready", 32'(req_ready), 32'b100);
    check32("t5_terr", 32'(timeout_err), 32'h0);
    check32("t5_rdata", req_rdata, 32'hCAFEF00D);
    endCycle();

    // Reset while busy with two waited cycles.
    applyStimulus(1'b0, 3'b010, 1'b0, 32'h0); endCycle();
    applyStimulus(1'b0, 3'b010, 1'b0, 32'h0); endCycle();
    applyStimulus(1'b0, 3'b010, 1'b0, 32'h0); endCycle();
    applyStimulus(1'b1, 3'b010, 1'b0, 32'h0);
    check32("t6_no_ready", 32'(req_ready), 32'h0);
    endCycle();
    applyStimulus(1'b0, 3'b011, 1'b0, 32'h0);
    check32("t6_valid_drop", 32'(mem_valid), 32'h0);
    check32("t6_ready_drop", 32'(req_ready), 32'h0);
    endCycle();
    applyStimulus(1'b0, 3'b011, 1'b0, 32'h0);
    check32("t6_port0_wins", 32'(grant_id), 32'h0);
    endCycle();
    applyStimulus(1'b0, 3'b011, 1'b1, 32'h5); endCycle();
    applyStimulus(1'b0, 3'b010, 1'b1, 32'h6); endCycle();
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0); endCycle();

    // Randomized traffic with requesters that honour the hold rules.
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]   = 1'b1;
          addrA[i]  = $urandom;
          wdataA[i] = $urandom;
          wstrbA[i] = 4'($urandom_range(0, 15));
        end
      end
      applyStimulus(($urandom_range(0, 299) == 0), pend,
                    ($urandom_range(0, 99) < 35), $urandom);
      endCycle();
      pend = pend & ~lastExpReady;
    end

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
